echo_request_serializer: RTL and testbench
==========================================

Name: echo_request_serializer

Overview:
- Downstream neighbour of the request-output stage: accepts 192-bit tagged request messages on a pipe enq interface and emits them as 32-bit beats (header, then payload words) toward a narrow transport.
- Buffers up to DEPTH whole messages so a new message can be accepted while the previous one is still serializing.
- Drops messages with unknown tags and counts the drops.

Parameters:
- DEPTH, 2, message buffer entries; power of 2, minimum 2.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- pipe$enq__ENA  in  1  enqueue strobe. Upstream asserts it only while pipe$enq__RDY=1; the block gates it internally with RDY regardless.
- pipe$enq_v  in  192  message: tag=[31:0]; tag 1 (say) meth=[63:32], v=[95:64]; tag 2 (say2) meth=[127:96], v=[159:128]; [191:160] unused.
- pipe$enq__RDY  out  1  buffer has a free entry
- beat$enq__ENA  out  1  beat valid and transferred this cycle
- beat$enq_v  out  32  beat data
- beat$enq__RDY  in  1  downstream can accept a beat
- drop_count  out  DROP_W  saturating count of dropped (unknown-tag) messages

Behaviour:
- Reset is asynchronous on nRST low. It clears the buffer pointers, occupancy, FSM state (IDLE), beat index and drop_count. During and after reset: pipe$enq__RDY=1 (from the first cycle after release), beat$enq__ENA=0, beat$enq_v=0, drop_count=0. Reset mid-message discards all buffered messages; no partial beat stream resumes.
- Enqueue:
  - A transfer occurs when pipe$enq__ENA & pipe$enq__RDY.
  - pipe$enq__RDY = (occupancy < DEPTH).
  - No bypass: RDY does not depend on a same-cycle dequeue.
  - Tags 1 and 2 are written at the write pointer, and occupancy increments.
  - Any other tag is not stored; drop_count increments, saturating at all-ones. The message is still considered accepted (RDY handshake completes).
- FSM states IDLE, HDR, PAY:
  - IDLE: when occupancy>0, go to HDR next cycle.
  - HDR: beat$enq_v = {16'd2, tag[15:0]} (payload length, tag). beat$enq__ENA = beat$enq__RDY. On transfer: go to PAY, k=0.
  - PAY: beat$enq_v = payload word k. Tag 1: k=0 → [63:32], k=1 → [95:64]. Tag 2: k=0 → [127:96], k=1 → [159:128].
    - On transfer with k=0: k=1.
    - On transfer with k=1: pop the entry (read pointer+1, occupancy-1). Then go to HDR if another entry remains (occupancy after pop >0), else IDLE. No idle cycle between back-to-back messages.
  - beat$enq_v = 0 in IDLE.
  - beat$enq_v is held stable while beat$enq__RDY=0.
- Latency: a message accepted in cycle N with the buffer empty has its header available in cycle N+2 (N+1 latch, IDLE→HDR), followed by 2 payload beats. Throughput is 3 beats per message with continuous RDY.
- Simultaneous push and final-beat pop in one cycle: occupancy is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- beat$enq__ENA is never asserted while beat$enq__RDY=0. Outputs are registered state / simple decode of state; no combinational path from pipe$enq__ENA to beat outputs.

Decomposition:
- Shared package:
  - tag constants TAG_SAY=1, TAG_SAY2=2
  - field offsets (TAG_LSB, SAY_METH_LSB, SAY_V_LSB, SAY2_METH_LSB, SAY2_V_LSB)
  - MSG_W=192, BEAT_W=32, PAYLOAD_WORDS=2
  - FSM state enum
- One natural sub-module: echo_msg_buffer (DEPTH×192 circular buffer with push/pop/occupancy). The serializer FSM and drop logic stay in the top.

Test Plan:
- Reset state: assert nRST low mid-stream with 2 messages buffered -> after release: occupancy 0, beat$enq__ENA=0, pipe$enq__RDY=1, drop_count=0.
- Single say: enq tag=1, meth=0x11, v=0x22 with beat RDY=1 -> beats 0x00020001, 0x00000011, 0x00000022 on consecutive cycles starting N+2.
- Back-pressure/full: beat RDY=0; enq say2 (meth=0xA, v=0xB) then say (0xC, 0xD) -> pipe$enq__RDY=0 after the 2nd. Third enq is held off. Release RDY -> 6 beats: 0x00020002, 0xA, 0xB, 0x00020001, 0xC, 0xD, with no gap. Stall RDY mid-payload -> beat_v stable.
- Simultaneous push/pop: buffer full, enq on the cycle the last payload beat transfers -> RDY rule is no-bypass, so the enq waits exactly one cycle. Order is preserved across pointer wrap (≥5 messages).
- Bad tag: enq tag=7 -> no beats emitted, drop_count=1. 300 bad tags -> drop_count=255 (saturated).

Source files
------------

// File: rtl/echo_request_serializer_pkg.sv
// Shared types and field layout for the echo request serializer.
// Message layout: tag in the low word, then per-tag method and value words.
package echo_request_serializer_pkg;

    localparam int unsigned MSG_W         = 192;
    localparam int unsigned BEAT_W        = 32;
    localparam int unsigned PAYLOAD_WORDS = 2;

    localparam logic [31:0] TAG_SAY  = 32'd1;
    localparam logic [31:0] TAG_SAY2 = 32'd2;

    localparam int unsigned TAG_LSB       = 0;
    localparam int unsigned SAY_METH_LSB  = 32;
    localparam int unsigned SAY_V_LSB     = 64;
    localparam int unsigned SAY2_METH_LSB = 96;
    localparam int unsigned SAY2_V_LSB    = 128;

    typedef enum logic [1:0] {
        StIdle,
        StHdr,
        StPay
    } ser_state_e;

    function automatic logic tag_is_known(input logic [31:0] tag);
        return (tag == TAG_SAY) || (tag == TAG_SAY2);
    endfunction

endpackage

// File: rtl/echo_request_serializer_if.sv
// Handshake bundle: wide message enqueue in, narrow beat enqueue out.
// The master side is the environment; the serializer uses the slave modport.
interface echo_request_serializer_if;
    import echo_request_serializer_pkg::*;

    logic              pipe_enq_ena;
    logic [MSG_W-1:0]  pipe_enq_v;
    logic              pipe_enq_rdy;
    logic              beat_enq_ena;
    logic [BEAT_W-1:0] beat_enq_v;
    logic              beat_enq_rdy;

    modport master (
        output pipe_enq_ena, pipe_enq_v, beat_enq_rdy,
        input  pipe_enq_rdy, beat_enq_ena, beat_enq_v
    );

    modport slave (
        input  pipe_enq_ena, pipe_enq_v, beat_enq_rdy,
        output pipe_enq_rdy, beat_enq_ena, beat_enq_v
    );

endinterface

// File: rtl/echo_msg_buffer.sv
// Circular buffer of whole messages; head is the oldest entry.
// Pointers wrap naturally because DEPTH is a power of two.
module echo_msg_buffer
    import echo_request_serializer_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [MSG_W-1:0] push_data,
    input  logic             pop,
    output logic [MSG_W-1:0] head,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [MSG_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy guards every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_data;
    end

    assign head  = mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/echo_request_serializer.sv
// Accepts tagged 192-bit messages, drops unknown tags, and emits each stored
// message as a header beat followed by its two payload words.
module echo_request_serializer
    import echo_request_serializer_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DROP_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    echo_request_serializer_if.slave bus,
    output logic [DROP_W-1:0]     drop_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0]  count;
    logic [MSG_W-1:0]  head;
    ser_state_e        state_q;
    logic              word_q;
    logic [DROP_W-1:0] drop_q;
    logic              enq_rdy, enq_xfer, tag_ok, push, beat_xfer, pop, more, head_say2;
    logic [BEAT_W-1:0] beat_v;

    // No bypass: readiness depends only on stored occupancy.
    assign enq_rdy   = count < CNT_W'(DEPTH);
    assign enq_xfer  = bus.pipe_enq_ena & enq_rdy;
    assign tag_ok    = tag_is_known(bus.pipe_enq_v[TAG_LSB +: 32]);
    assign push      = enq_xfer & tag_ok;
    assign beat_xfer = (state_q != StIdle) & bus.beat_enq_rdy;
    assign pop       = (state_q == StPay) & word_q & beat_xfer;
    assign more      = (count > CNT_W'(1)) | push;
    assign head_say2 = head[TAG_LSB +: 32] == TAG_SAY2;

    echo_msg_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (bus.pipe_enq_v),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            word_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: if (count != '0) state_q <= StHdr;
                StHdr: begin
                    if (beat_xfer) begin
                        state_q <= StPay;
                        word_q  <= 1'b0;
                    end
                end
                StPay: begin
                    if (beat_xfer) begin
                        if (!word_q) word_q <= 1'b1;
                        else         state_q <= more ? StHdr : StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
            if (enq_xfer && !tag_ok && drop_q != '1) drop_q <= drop_q + 1'b1;
        end
    end

    always_comb begin
        beat_v = '0;
        case (state_q)
            StHdr: beat_v = {16'(PAYLOAD_WORDS), head[TAG_LSB +: 16]};
            StPay: begin
                if (head_say2) beat_v = word_q ? head[SAY2_V_LSB +: BEAT_W]
                                               : head[SAY2_METH_LSB +: BEAT_W];
                else           beat_v = word_q ? head[SAY_V_LSB +: BEAT_W]
                                               : head[SAY_METH_LSB +: BEAT_W];
            end
            default: beat_v = '0;
        endcase
    end

    assign bus.pipe_enq_rdy = enq_rdy;
    assign bus.beat_enq_ena = beat_xfer;
    assign bus.beat_enq_v   = beat_v;
    assign drop_count       = drop_q;

endmodule

// File: tb/tb_echo_request_serializer.sv
// Bench for echo_request_serializer: queue-based reference model checked every
// cycle, plus directed scenarios with literal expected beats and timing.
module tb_echo_request_serializer;

    localparam int unsigned DEPTH  = 2;
    localparam int unsigned DROP_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [DROP_W-1:0] drop_count;

    echo_request_serializer_if bus();

    echo_request_serializer #(
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] v;
        int          c;
    } beat_rec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state: stored messages, whether the head is being shown, beat index.
    logic [191:0] q[$];
    bit           active = 0;
    int           b      = 0;
    int           drops  = 0;
    beat_rec_t    log_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [191:0] mk(input logic [31:0] tag, input logic [31:0] a,
                                        input logic [31:0] bb);
        logic [191:0] m;
        for (int i = 0; i < 6; i++) m[i*32 +: 32] = $urandom;
        m[31:0] = tag;
        if (tag == 32'd2) begin
            m[127:96]  = a;
            m[159:128] = bb;
        end else begin
            m[63:32] = a;
            m[95:64] = bb;
        end
        return m;
    endfunction

    function automatic logic [31:0] exp_beat(input logic [191:0] m, input int idx);
        logic [31:0] tag;
        tag = m[31:0];
        if (idx == 0) return {16'd2, tag[15:0]};
        if (tag == 32'd2) return (idx == 1) ? m[127:96] : m[159:128];
        return (idx == 1) ? m[63:32] : m[95:64];
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            active = 0;
            b      = 0;
            drops  = 0;
            check("rst_beat_ena", 64'(bus.beat_enq_ena), 64'd0);
            check("rst_beat_v", 64'(bus.beat_enq_v), 64'd0);
            check("rst_drop", 64'(drop_count), 64'd0);
        end else begin
            logic [31:0] ev;
            logic        xfer_in, tag_ok;
            ev = active ? exp_beat(q[0], b) : 32'd0;
            check("beat_ena", 64'(bus.beat_enq_ena), 64'(active && bus.beat_enq_rdy));
            check("beat_v", 64'(bus.beat_enq_v), 64'(ev));
            check("pipe_rdy", 64'(bus.pipe_enq_rdy), 64'(q.size() < DEPTH));
            check("drop_count", 64'(drop_count), 64'(drops));
            if (bus.beat_enq_ena) log_q.push_back('{v: bus.beat_enq_v, c: cyc});
            xfer_in = bus.pipe_enq_ena && (q.size() < DEPTH);
            tag_ok  = (bus.pipe_enq_v[31:0] == 32'd1) || (bus.pipe_enq_v[31:0] == 32'd2);
            if (active) begin
                if (bus.beat_enq_rdy) begin
                    b++;
                    if (b == 3) begin
                        void'(q.pop_front());
                        b      = 0;
                        active = (q.size() + ((xfer_in && tag_ok) ? 1 : 0)) > 0;
                    end
                end
            end else begin
                active = q.size() > 0;
            end
            if (xfer_in) begin
                if (tag_ok) q.push_back(bus.pipe_enq_v);
                else if (drops < 255) drops++;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [191:0] m, output int acc);
        int n;
        n = 0;
        bus.pipe_enq_ena = 1'b1;
        bus.pipe_enq_v   = m;
        while (!bus.pipe_enq_rdy && n < 200) begin
            tick();
            n++;
        end
        acc = cyc;
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL send_timeout: rdy stayed 0 for %0d cycles, required 1", n);
        end
        tick();
        bus.pipe_enq_ena = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.beat_enq_rdy = 1'b1;
        while ((q.size() != 0 || active) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d still queued, required 0", q.size());
        end
        tick();
    endtask

    task automatic check_log(input int idx, input logic [31:0] v, input int c);
        if (log_q.size() > idx) begin
            check($sformatf("log_v[%0d]", idx), 64'(log_q[idx].v), 64'(v));
            check($sformatf("log_cyc[%0d]", idx), 64'(log_q[idx].c), 64'(c));
        end else begin
            check($sformatf("log_len>%0d", idx), 64'(log_q.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        int acc, acc2;
        logic [31:0] tags[6];
        tags = '{32'd1, 32'd2, 32'd1, 32'd2, 32'd7, 32'd0};
        bus.pipe_enq_ena = 1'b0;
        bus.pipe_enq_v   = '0;
        bus.beat_enq_rdy = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rdy_after_reset", 64'(bus.pipe_enq_rdy), 64'd1);

        // Single say with continuous downstream ready.
        bus.beat_enq_rdy = 1'b1;
        log_q.delete();
        send(mk(32'd1, 32'h11, 32'h22), acc);
        repeat (6) tick();
        check("single_len", 64'(log_q.size()), 64'd3);
        check_log(0, 32'h0002_0001, acc + 2);
        check_log(1, 32'h0000_0011, acc + 3);
        check_log(2, 32'h0000_0022, acc + 4);

        // Fill under back-pressure, hold off a third, then release.
        bus.beat_enq_rdy = 1'b0;
        log_q.delete();
        send(mk(32'd2, 32'hA, 32'hB), acc);
        send(mk(32'd1, 32'hC, 32'hD), acc);
        check("full_rdy", 64'(bus.pipe_enq_rdy), 64'd0);
        bus.pipe_enq_ena = 1'b1;
        bus.pipe_enq_v   = mk(32'd1, 32'hEE, 32'hFF);
        repeat (3) tick();
        bus.pipe_enq_ena = 1'b0;
        bus.beat_enq_rdy = 1'b1;
        repeat (8) tick();
        check("bp_len", 64'(log_q.size()), 64'd6);
        if (log_q.size() >= 6) begin
            check_log(0, 32'h0002_0002, log_q[0].c);
            check_log(1, 32'hA, log_q[0].c + 1);
            check_log(2, 32'hB, log_q[0].c + 2);
            check_log(3, 32'h0002_0001, log_q[0].c + 3);
            check_log(4, 32'hC, log_q[0].c + 4);
            check_log(5, 32'hD, log_q[0].c + 5);
        end

        // Stall between the two payload words: beat data must hold.
        bus.beat_enq_rdy = 1'b0;
        send(mk(32'd1, 32'h31, 32'h32), acc);
        send(mk(32'd2, 32'h41, 32'h42), acc);
        bus.beat_enq_rdy = 1'b1;
        tick();
        tick();
        bus.beat_enq_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_v", 64'(bus.beat_enq_v), 64'h32);
            check("stall_ena", 64'(bus.beat_enq_ena), 64'd0);
        end
        drain();

        // Full buffer: an enqueue waits until the cycle after the final-beat pop.
        bus.beat_enq_rdy = 1'b0;
        log_q.delete();
        send(mk(32'd1, 32'h51, 32'h52), acc);
        send(mk(32'd2, 32'h61, 32'h62), acc);
        bus.beat_enq_rdy = 1'b1;
        send(mk(32'd2, 32'h71, 32'h72), acc2);
        if (log_q.size() > 0) check("nobypass_wait", 64'(acc2 - log_q[0].c), 64'd3);
        else check("nobypass_log", 64'(log_q.size()), 64'd1);
        for (int i = 0; i < 4; i++) send(mk(tags[i], 32'h80 + i, 32'h90 + i), acc);
        drain();
        check("wrap_len", 64'(log_q.size()), 64'd21);

        // Reset with two messages buffered discards them.
        bus.beat_enq_rdy = 1'b0;
        send(mk(32'd1, 32'h1, 32'h2), acc);
        send(mk(32'd2, 32'h3, 32'h4), acc);
        rst_n = 1'b0;
        tick();
        log_q.delete();
        rst_n = 1'b1;
        bus.beat_enq_rdy = 1'b1;
        tick();
        check("post_rst_rdy", 64'(bus.pipe_enq_rdy), 64'd1);
        check("post_rst_ena", 64'(bus.beat_enq_ena), 64'd0);
        repeat (5) tick();
        check("post_rst_no_beats", 64'(log_q.size()), 64'd0);

        // Unknown tags: one drop, then saturation.
        send(mk(32'd7, 32'h5, 32'h6), acc);
        repeat (5) tick();
        check("bad_tag_no_beats", 64'(log_q.size()), 64'd0);
        check("bad_tag_drop1", 64'(drop_count), 64'd1);
        for (int i = 0; i < 299; i++) send(mk(32'd7, 32'h0, 32'h0), acc);
        tick();
        check("drop_saturated", 64'(drop_count), 64'd255);

        // Randomized traffic from a fresh reset.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bus.beat_enq_rdy = ($urandom_range(3) != 0);
            bus.pipe_enq_ena = $urandom_range(1) == 1;
            bus.pipe_enq_v   = mk(tags[$urandom_range(5)], $urandom, $urandom);
            tick();
        end
        bus.pipe_enq_ena = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
